// File: rtl/if_stage_if.sv
// Instruction-memory fetch port shared by the fetch stage (master) and the
// instruction memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the PC, fetches from instruction memory,
// parks a fetched word during pipeline stalls and loads the IF/ID register.
module if_stage (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PcWrite,
  input  logic              IF_ID_Write,
  input  logic              pc_src,
  input  logic [31:0]       branch_target,
  if_stage_if.master        imem,
  output logic [31:0]       PC_ID,
  output logic [31:0]       Inst_ID,
  output logic              valid_ID,
  output logic              fetch_stall
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcId_q, pcId_d;
  logic [31:0] instId_q, instId_d;
  logic        validId_q, validId_d;
  logic [31:0] bufInst_q, bufInst_d;
  logic [31:0] bufPc_q, bufPc_d;

  logic        advance;
  logic [31:0] pcPlus4;

  assign advance = PcWrite & IF_ID_Write;
  assign pcPlus4 = pc_q + 32'd4;

  // A taken branch outranks every stall/fetch case and flushes the parked word.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pcId_d    = pcId_q;
    instId_d  = instId_q;
    validId_d = validId_q;
    bufInst_d = bufInst_q;
    bufPc_d   = bufPc_q;

    if (pc_src) begin
      pc_d      = branch_target & 32'hFFFF_FFFC;
      pcId_d    = 32'd0;
      instId_d  = NOP;
      validId_d = 1'b0;
      bufInst_d = 32'd0;
      bufPc_d   = 32'd0;
      state_d   = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            if (advance) begin
              pcId_d    = pc_q;
              instId_d  = imem.imem_rdata;
              validId_d = 1'b1;
              pc_d      = pcPlus4;
            end else begin
              bufPc_d   = pc_q;
              bufInst_d = imem.imem_rdata;
              state_d   = HOLD;
            end
          end else if (IF_ID_Write) begin
            pcId_d    = 32'd0;
            instId_d  = NOP;
            validId_d = 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            pcId_d    = bufPc_q;
            instId_d  = bufInst_q;
            validId_d = 1'b1;
            pc_d      = pcPlus4;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= 32'd0;
      pcId_q    <= 32'd0;
      instId_q  <= NOP;
      validId_q <= 1'b0;
      bufInst_q <= 32'd0;
      bufPc_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pcId_q    <= pcId_d;
      instId_q  <= instId_d;
      validId_q <= validId_d;
      bufInst_q <= bufInst_d;
      bufPc_q   <= bufPc_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign fetch_stall    = (state_q == FETCH) & ~imem.imem_ready;

  assign PC_ID    = pcId_q;
  assign Inst_ID  = instId_q;
  assign valid_ID = validId_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: memory returns address-tagged words
// {8'hA5, addr[23:0]} and expected values are written out by hand.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        PcWrite;
  logic        IF_ID_Write;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        memReady;
  logic [31:0] PC_ID;
  logic [31:0] Inst_ID;
  logic        valid_ID;
  logic        fetch_stall;

  int checkCount;
  int errorCount;

  if_stage_if bus ();

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PcWrite       (PcWrite),
    .IF_ID_Write   (IF_ID_Write),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem          (bus.master),
    .PC_ID         (PC_ID),
    .Inst_ID       (Inst_ID),
    .valid_ID      (valid_ID),
    .fetch_stall   (fetch_stall)
  );

  // Memory model: an address-tagged word, garbage when not ready.
  assign bus.imem_ready = memReady;
  assign bus.imem_rdata = memReady ? {8'hA5, bus.imem_addr[23:0]} : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic pcw, input logic ifidw,
                               input logic ready, input logic src,
                               input logic [31:0] target);
    rst_n         = rstn;
    PcWrite       = pcw;
    IF_ID_Write   = ifidw;
    memReady      = ready;
    pc_src        = src;
    branch_target = target;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic vld);
    checkOutput({tag, "_pc"},    PC_ID,   pc);
    checkOutput({tag, "_inst"},  Inst_ID, inst);
    checkOutput({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, vld});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    stepClock();
    stepClock();
    checkIfId("reset", 32'd0, 32'h0000_0013, 1'b0);
    checkOutput("reset_addr", bus.imem_addr, 32'd0);
    checkOutput("reset_req", {31'd0, bus.imem_req}, 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("first_addr", bus.imem_addr, 32'd0);
    checkOutput("first_req", {31'd0, bus.imem_req}, 32'd1);
    stepClock();
    checkIfId("line0", 32'd0, 32'hA500_0000, 1'b1);
    checkOutput("line0_addr", bus.imem_addr, 32'd4);
    stepClock();
    checkIfId("line4", 32'd4, 32'hA500_0004, 1'b1);
    checkOutput("line4_addr", bus.imem_addr, 32'd8);

    // Load-use stall at PC=8 parks the word.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkIfId("hold", 32'd4, 32'hA500_0004, 1'b1);
    checkOutput("hold_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("hold_addr", bus.imem_addr, 32'd8);
    checkOutput("hold_stall", {31'd0, fetch_stall}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkIfId("unpark8", 32'd8, 32'hA500_0008, 1'b1);
    checkOutput("unpark8_addr", bus.imem_addr, 32'd12);
    checkOutput("unpark8_req", {31'd0, bus.imem_req}, 32'd1);
    stepClock();
    checkIfId("line12", 32'd12, 32'hA500_000C, 1'b1);
    checkOutput("line12_addr", bus.imem_addr, 32'd16);

    // Three-cycle memory wait at PC=16.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("wait_stall", {31'd0, fetch_stall}, 32'd1);
      stepClock();
      checkIfId("wait_bubble", 32'd0, 32'h0000_0013, 1'b0);
      checkOutput("wait_addr", bus.imem_addr, 32'd16);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("wait_done_stall", {31'd0, fetch_stall}, 32'd0);
    stepClock();
    checkIfId("line16", 32'd16, 32'hA500_0010, 1'b1);
    checkOutput("line16_addr", bus.imem_addr, 32'd20);

    // Park word@20, then redirect while in HOLD with a stall still asserted.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkOutput("hold20_req", {31'd0, bus.imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    stepClock();
    checkIfId("redir", 32'd0, 32'h0000_0013, 1'b0);
    checkOutput("redir_addr", bus.imem_addr, 32'h0000_0100);
    checkOutput("redir_req", {31'd0, bus.imem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkIfId("line100", 32'h100, 32'hA500_0100, 1'b1);
    checkOutput("line100_addr", bus.imem_addr, 32'h0000_0104);

    // Memory wait with IF_ID_Write=0: IF/ID keeps its instruction.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    stepClock();
    checkIfId("waitkeep", 32'h100, 32'hA500_0100, 1'b1);
    checkOutput("waitkeep_addr", bus.imem_addr, 32'h0000_0104);

    // PC wrap: redirect to the top word, then advance.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    stepClock();
    checkOutput("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkIfId("wrap", 32'hFFFF_FFFC, 32'hA5FF_FFFC, 1'b1);
    checkOutput("wrap_addr", bus.imem_addr, 32'd0);
    stepClock();
    checkOutput("after_wrap_addr", bus.imem_addr, 32'd4);

    // Reset in HOLD with a simultaneous redirect: reset wins, parked word lost.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkOutput("hold4_req", {31'd0, bus.imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    stepClock();
    checkIfId("rstdom", 32'd0, 32'h0000_0013, 1'b0);
    checkOutput("rstdom_addr", bus.imem_addr, 32'd0);
    checkOutput("rstdom_req", {31'd0, bus.imem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    stepClock();
    checkIfId("post_rst", 32'd0, 32'hA500_0000, 1'b1);
    checkOutput("post_rst_addr", bus.imem_addr, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk.
REQ-004 PcWrite  input  1  from hazard detection; 1 = PC may advance.
REQ-005 IF_ID_Write  input  1  from hazard detection; 1 = IF/ID register may load.
REQ-006 pc_src  input  1  branch/jump taken, resolved in EX; 1 = redirect.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address; always equals PC.
REQ-010 imem_rdata  input  32  instruction for imem_addr, valid when imem_ready=1.
REQ-011 imem_ready  input  1  memory returns data this cycle; memory keeps no outstanding state.
REQ-012 PC_ID  output  32  PC of instruction held in IF/ID.
REQ-013 Inst_ID  output  32  instruction held in IF/ID.
REQ-014 valid_ID  output  1  1 = Inst_ID is a real instruction, 0 = bubble.
REQ-015 fetch_stall  output  1  1 = waiting on memory this cycle.

Function
REQ-016 States SHALL be FETCH (imem_req=1) and HOLD (imem_req=0, fetched word parked in a 32-bit hold buffer with its PC).
REQ-017 advance SHALL be defined as PcWrite=1 AND IF_ID_Write=1; any other combination is a stall.
REQ-018 FETCH, imem_ready=1, advance: IF/ID <= {PC, imem_rdata, valid 1}; PC <= PC+4; stay FETCH.
REQ-019 FETCH, imem_ready=1, no advance: buffer <= {PC, imem_rdata}; PC and IF/ID hold; go HOLD.
REQ-020 FETCH, imem_ready=0: PC holds; if IF_ID_Write=1, IF/ID <= bubble, otherwise IF/ID holds; stay FETCH.
REQ-021 HOLD, advance: IF/ID <= buffer with valid 1; PC <= PC+4; go FETCH.
REQ-022 HOLD, no advance: everything holds; stay HOLD.
REQ-023 Bubble SHALL be Inst_ID=32'h00000013 (NOP), valid_ID=0, PC_ID=0.
REQ-024 pc_src=1 SHALL override REQ-018..022 in any state, regardless of PcWrite/IF_ID_Write: PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble; buffer discarded; go FETCH.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 0.
REQ-026 fetch_stall SHALL equal (state==FETCH) AND imem_ready=0, combinationally.
REQ-027 Latency: instruction at PC SHALL appear on Inst_ID one clk edge after the cycle imem_ready=1 with advance.
REQ-028 PC[1:0] SHALL always be 0.

Reset
REQ-029 rst_n=0 at a clk edge SHALL force: PC=0, state=FETCH, IF/ID=bubble, buffer=0; it overrides pc_src.
REQ-030 Reset mid-HOLD or mid-wait SHALL discard the parked/pending instruction.
REQ-031 After reset release, imem_req=1 and imem_addr=0 in the first cycle.

Verification
REQ-032 Straight-line: ready always 1, advance always 1, rdata=PC-tagged words -> Inst_ID follows addresses 0,4,8,... one cycle late, valid_ID=1.
REQ-033 Load-use stall: PcWrite=0, IF_ID_Write=0 for 1 cycle at PC=8 -> state HOLD; next cycle word@8 loads to IF/ID, PC=12; no instruction lost or duplicated.
REQ-034 Memory wait: imem_ready=0 for 3 cycles at PC=16 -> fetch_stall=1 three cycles, valid_ID=0 bubbles, PC stays 16.
REQ-035 Redirect during HOLD: pc_src=1, branch_target=32'h00000103 -> PC=32'h00000100, valid_ID=0, state FETCH, parked word dropped.
REQ-036 Wrap: PC=32'hFFFFFFFC, advance -> PC=0.
REQ-037 Reset dominance: rst_n=0 with pc_src=1 in the same cycle -> PC=0, IF/ID bubble.
